// File: rtl/bus_sram_slave_pkg.sv
// bus_sram_slave_pkg: shared FSM encoding and bus field widths for the SRAM bus slave.
package bus_sram_slave_pkg;
    localparam int AD_W = 32;
    localparam int BE_W = 4;
    localparam int BURST_W = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_END, ST_ERROR} state_t;
endpackage

// File: rtl/sram2048x32_be.sv
// sram2048x32_be: single-port synchronous SRAM, byte write enables, registered read held when re_i=0.
module sram2048x32_be #(
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem [2**AW];
    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int b = 0; b < 4; b++)
                if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        if (re_i) rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/bus_sram_slave.sv
// bus_sram_slave: burst bus responder over a private byte-writable SRAM.
// Reads run as a fetch stage (SRAM register) feeding a registered output stage; both freeze on stall.
module bus_sram_slave
    import bus_sram_slave_pkg::*;
#(
    parameter logic [31:0]        baseAddress  = 32'h4000_0000,
    parameter int                 sizeInBytes  = 8192,
    parameter logic [BURST_W-1:0] maxBurstSize = 8'd15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               beginTransactionIn,
    input  logic               endTransactionIn,
    input  logic               readNotWriteIn,
    input  logic               dataValidIn,
    input  logic               busyIn,
    input  logic [AD_W-1:0]    addressDataIn,
    input  logic [BE_W-1:0]    byteEnablesIn,
    input  logic [BURST_W-1:0] burstSizeIn,
    output logic               dataValidOut,
    output logic               endTransactionOut,
    output logic               busErrorOut,
    output logic               busyOut,
    output logic [AD_W-1:0]    addressDataOut
);
    localparam int DW = $clog2(sizeInBytes);
    localparam int IW = DW - 2;
    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [BE_W-1:0]    be_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W:0]   beat_q, issue_q;
    logic               rvalid_q, dvo_q, eto_q, err_q;
    logic [AD_W-1:0]    data_q, rdata;
    logic               sel, advance, issue, we;
    assign sel     = beginTransactionIn && (addressDataIn[31:DW] == baseAddress[31:DW]);
    assign advance = !(busyIn && dvo_q);
    assign issue   = (state_q == ST_READ) && advance && (issue_q <= {1'b0, burst_q});
    assign we      = (state_q == ST_WRITE) && dataValidIn && (beat_q <= {1'b0, burst_q});
    assign dataValidOut      = dvo_q;
    assign endTransactionOut = eto_q;
    assign busErrorOut       = err_q;
    assign busyOut           = 1'b0;
    assign addressDataOut    = data_q;
    sram2048x32_be #(.AW(IW)) u_sram (
        .clk_i(clock), .we_i(we), .re_i(issue), .be_i(be_q),
        .addr_i(idx_q), .wdata_i(addressDataIn), .rdata_o(rdata)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            be_q     <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            issue_q  <= '0;
            rvalid_q <= 1'b0;
            dvo_q    <= 1'b0;
            eto_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (sel) begin
                    idx_q    <= addressDataIn[DW-1:2];
                    be_q     <= byteEnablesIn;
                    burst_q  <= burstSizeIn;
                    beat_q   <= '0;
                    issue_q  <= '0;
                    rvalid_q <= 1'b0;
                    if (burstSizeIn > maxBurstSize) begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                        eto_q   <= 1'b1;
                    end else state_q <= readNotWriteIn ? ST_READ : ST_WRITE;
                end
                ST_WRITE: begin
                    if (we) begin
                        idx_q  <= idx_q + IW'(1);
                        beat_q <= beat_q + 9'd1;
                    end
                    if (endTransactionIn) state_q <= ST_IDLE;
                end
                ST_READ: if (endTransactionIn) begin
                    state_q  <= ST_IDLE;
                    rvalid_q <= 1'b0;
                    dvo_q    <= 1'b0;
                    data_q   <= '0;
                end else begin
                    if (issue) begin
                        idx_q   <= idx_q + IW'(1);
                        issue_q <= issue_q + 9'd1;
                    end
                    if (advance) begin
                        rvalid_q <= issue;
                        dvo_q    <= rvalid_q;
                        data_q   <= rvalid_q ? rdata : '0;
                    end
                    // last beat accepted: overrides the output-stage update above
                    if (dvo_q && !busyIn) begin
                        beat_q <= beat_q + 9'd1;
                        if (beat_q == {1'b0, burst_q}) begin
                            state_q <= ST_END;
                            eto_q   <= 1'b1;
                            dvo_q   <= 1'b0;
                            data_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    eto_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: directed self-checking bench; inputs change 2 time units after each rising edge.
module tb_bus_sram_slave;
    logic        clock = 1'b0, reset = 1'b0;
    logic        beginTransactionIn = 1'b0, endTransactionIn = 1'b0, readNotWriteIn = 1'b0;
    logic        dataValidIn = 1'b0, busyIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic [3:0]  byteEnablesIn = '0;
    logic [7:0]  burstSizeIn = '0;
    logic        dataValidOut, endTransactionOut, busErrorOut, busyOut;
    logic [31:0] addressDataOut;
    int total = 0, bad = 0;

    bus_sram_slave dut (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .busyIn(busyIn),
        .addressDataIn(addressDataIn), .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
        .busErrorOut(busErrorOut), .busyOut(busyOut), .addressDataOut(addressDataOut)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] outs();
        return {dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut};
    endfunction

    function automatic logic [35:0] beat(input logic [31:0] d);
        return {4'b1000, d};
    endfunction

    task automatic start(input logic [31:0] a, input logic rnw, input logic [3:0] be, input logic [7:0] bs);
        beginTransactionIn = 1'b1;
        addressDataIn = a;
        readNotWriteIn = rnw;
        byteEnablesIn = be;
        burstSizeIn = bs;
        step();
        beginTransactionIn = 1'b0;
        addressDataIn = '0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic last);
        dataValidIn = 1'b1;
        addressDataIn = d;
        endTransactionIn = last;
        step();
        dataValidIn = 1'b0;
        endTransactionIn = 1'b0;
        addressDataIn = '0;
    endtask

    initial begin
        step();
        step();
        chk("reset_outs", outs(), 36'h0);
        reset = 1'b1;
        step();
        // single write then single read, first beat two cycles after begin
        start(32'h4000_0010, 1'b0, 4'hF, 8'd0);
        chk("write_outs_zero", outs(), 36'h0);
        wbeat(32'hDEAD_BEEF, 1'b1);
        start(32'h4000_0010, 1'b1, 4'hF, 8'd0);
        chk("rd1_lat0", outs(), 36'h0);
        step();
        chk("rd1_lat1", outs(), 36'h0);
        step();
        chk("rd1_beat", outs(), beat(32'hDEAD_BEEF));
        step();
        chk("rd1_end", outs(), {4'b0100, 32'h0});
        step();
        chk("rd1_idle", outs(), 36'h0);
        // byte-enable write over a zeroed word
        start(32'h4000_0000, 1'b0, 4'hF, 8'd0);
        wbeat(32'h0, 1'b1);
        start(32'h4000_0003, 1'b0, 4'b0101, 8'd0);
        wbeat(32'h1122_3344, 1'b1);
        start(32'h4000_0000, 1'b1, 4'hF, 8'd0);
        step();
        step();
        chk("be_read", outs(), beat(32'h0022_0044));
        step();
        chk("be_end", outs(), {4'b0100, 32'h0});
        step();
        // burst write wrapping 2047 -> 0, then burst read back
        start(32'h4000_1FF8, 1'b0, 4'hF, 8'd3);
        wbeat(32'd1, 1'b0);
        wbeat(32'd2, 1'b0);
        wbeat(32'd3, 1'b0);
        wbeat(32'd4, 1'b1);
        start(32'h4000_1FF8, 1'b1, 4'hF, 8'd3);
        step();
        step();
        chk("wrap_b1", outs(), beat(32'd1));
        step();
        chk("wrap_b2", outs(), beat(32'd2));
        step();
        chk("wrap_b3", outs(), beat(32'd3));
        step();
        chk("wrap_b4", outs(), beat(32'd4));
        step();
        chk("wrap_end", outs(), {4'b0100, 32'h0});
        step();
        chk("wrap_idle", outs(), 36'h0);
        // read stall: busy for 3 cycles on beat 2 holds it 4 cycles
        start(32'h4000_1FF8, 1'b1, 4'hF, 8'd3);
        step();
        step();
        chk("stall_b1", outs(), beat(32'd1));
        step();
        chk("stall_b2", outs(), beat(32'd2));
        busyIn = 1'b1;
        step();
        chk("stall_hold1", outs(), beat(32'd2));
        step();
        chk("stall_hold2", outs(), beat(32'd2));
        step();
        chk("stall_hold3", outs(), beat(32'd2));
        busyIn = 1'b0;
        step();
        chk("stall_b3", outs(), beat(32'd3));
        step();
        chk("stall_b4", outs(), beat(32'd4));
        step();
        chk("stall_end", outs(), {4'b0100, 32'h0});
        step();
        // oversize burst errors for one cycle and writes nothing
        start(32'h4000_0010, 1'b0, 4'hF, 8'd16);
        chk("err_resp", outs(), {4'b0110, 32'h0});
        wbeat(32'h1234_5678, 1'b1);
        chk("err_clear", outs(), 36'h0);
        start(32'h4000_0010, 1'b1, 4'hF, 8'd0);
        step();
        step();
        chk("err_mem_kept", outs(), beat(32'hDEAD_BEEF));
        step();
        step();
        // unselected begin: outputs stay zero
        start(32'h5000_0000, 1'b1, 4'hF, 8'd0);
        chk("nosel_0", outs(), 36'h0);
        step();
        chk("nosel_1", outs(), 36'h0);
        step();
        chk("nosel_2", outs(), 36'h0);
        step();
        chk("nosel_3", outs(), 36'h0);
        // asynchronous reset during beat 2 of a burst-7 read
        start(32'h4000_1FF8, 1'b1, 4'hF, 8'd7);
        step();
        step();
        chk("rst_b1", outs(), beat(32'd1));
        step();
        chk("rst_b2", outs(), beat(32'd2));
        #1 reset = 1'b0;
        #1 chk("rst_async", outs(), 36'h0);
        step();
        chk("rst_held", outs(), 36'h0);
        reset = 1'b1;
        step();
        start(32'h4000_0010, 1'b1, 4'hF, 8'd0);
        step();
        step();
        chk("rst_readback", outs(), beat(32'hDEAD_BEEF));
        step();
        chk("rst_rb_end", outs(), {4'b0100, 32'h0});
        step();
        chk("final_idle", outs(), 36'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_sram_slave.md
Name: bus_sram_slave

Overview:
- Burst-capable bus responder with a private 8 KB single-clock SRAM (2048 x 32, byte-writable).
- Answers single and burst read/write transactions issued by bus initiators such as the scratchpad DMA engines.
- Sits on the shared bus next to the arbiter and the other slaves.
- Drives all outputs to zero when not addressed, so the bus can OR slave outputs together.

Parameters:
- baseAddress, 32'h40000000, slave base; bits [12:0] must be 0.
- sizeInBytes, 8192, memory size; power of two, decode width log2(sizeInBytes).
- maxBurstSize, 8'd15, largest accepted burstSizeIn (beats-1); larger requests are errored.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- beginTransactionIn  in  1  start-of-transaction strobe; address phase.
- endTransactionIn  in  1  initiator end or abort.
- readNotWriteIn  in  1  sampled with beginTransactionIn.
- dataValidIn  in  1  write beat valid.
- busyIn  in  1  initiator stall of read beats.
- addressDataIn  in  32  start address in address phase, write data otherwise.
- byteEnablesIn  in  4  sampled with beginTransactionIn; applies to every write beat.
- burstSizeIn  in  8  beats-1, sampled with beginTransactionIn.
- dataValidOut  out  1  read beat valid.
- endTransactionOut  out  1  slave-side end of a read or errored transaction.
- busErrorOut  out  1  error response.
- busyOut  out  1  constant 0; this slave never stalls.
- addressDataOut  out  32  read data; 0 when dataValidOut=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; all outputs 0.
  - Beat counter and address counter cleared.
  - SRAM contents are untouched.
- Select: beginTransactionIn=1 and addressDataIn[31:13]==baseAddress[31:13].
  - Address bits [1:0] are ignored.
  - Word index = addressDataIn[12:2].
- States:
  - IDLE: on select, latch index, byteEnables, burstSize and rnw. If burstSizeIn>maxBurstSize go to ERROR. Otherwise go to READ (rnw=1) or WRITE (rnw=0).
  - WRITE: each cycle with dataValidIn=1, write addressDataIn to index using the latched byteEnables, then index+1. endTransactionIn=1 returns to IDLE, even if fewer than burstSize+1 beats were received. Beats beyond burstSize+1 are ignored. endTransactionIn together with a final dataValidIn still writes that beat.
  - READ: read latency is 2 cycles from begin to the first dataValidOut. Beats are presented on consecutive cycles. With busyIn=1 and dataValidOut=1, the same beat (same data) is held and the address does not advance. After beat burstSize+1 is accepted (dataValidOut=1, busyIn=0), go to END.
  - END: endTransactionOut=1 for exactly one cycle, then IDLE.
  - ERROR: busErrorOut=1 and endTransactionOut=1 for one cycle, then IDLE. No memory access occurs.
- Index arithmetic: 11-bit, wraps 2047 -> 0 within a burst.
- Abort: endTransactionIn=1 in READ returns to IDLE next cycle with outputs 0 and no endTransactionOut.
- Unselected beginTransactionIn is ignored in every state. beginTransactionIn in a non-IDLE state is also ignored.
- busyIn is ignored outside READ.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WRITE, READ, END, ERROR).
  - Bus field widths (address/data 32, byte enables 4, burst 8).
- Natural sub-module: sram2048x32_be, a single-port synchronous SRAM with 4 byte write enables and registered read.

Test Plan:
- Single write then read:
  - Write at 0x40000010, be=4'hF, data 0xDEADBEEF.
  - Read burst 0 at 0x40000010 -> one beat 0xDEADBEEF, 2 cycles after begin; endTransactionOut on the next cycle.
- Byte-enable write:
  - Write 0x11223344 with be=4'b0101 over word 0x00000000 -> readback 0x00220044.
- Burst with wrap:
  - Write burst 3 at 0x40001FF8 with 1,2,3,4 -> words 2046, 2047, 0, 1 hold 1, 2, 3, 4.
  - Read burst 3 at the same address returns 1, 2, 3, 4 on consecutive cycles.
- Read stall:
  - Read burst 3 with busyIn=1 on beat 2 for 3 cycles -> beat 2 held for 4 cycles with stable data.
  - No beat is lost or duplicated; endTransactionOut follows beat 4.
- Error and decode:
  - burstSizeIn=16 -> busErrorOut and endTransactionOut for one cycle; memory unchanged.
  - Begin at 0x50000000 -> all outputs stay 0.
- Reset mid-burst:
  - Assert reset during beat 2 of a read burst 7 -> outputs 0 immediately (asynchronous).
  - After release, a new read returns the previously written data.
